// File: rtl/wb_regfile_if.sv
// Writeback bus from the MEM/WB pipeline register into the register file.
// The pipeline stage drives it as master; wb_regfile consumes it as slave.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic [DATA_W-1:0] W_Dout;
  logic [DATA_W-1:0] W_ALUout;
  logic [REG_AW-1:0] W_Rw;
  logic              W_MemtoReg;
  logic              W_RegWr;
  logic              W_Overflow;

  // No valid/ready: the pipeline presents one writeback every cycle and it is always accepted.
  modport master (
    output W_Dout, W_ALUout, W_Rw, W_MemtoReg, W_RegWr, W_Overflow
  );
  modport slave (
    input  W_Dout, W_ALUout, W_Rw, W_MemtoReg, W_RegWr, W_Overflow
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and 32-entry register file: result select, overflow-suppressed commit,
// two bypassed decode read ports, an unbypassed debug port, sticky overflow record and write counter.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_n,
  wb_regfile_if.slave       wb,
  input  logic [REG_AW-1:0] Ra,
  input  logic [REG_AW-1:0] Rb,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  input  logic [REG_AW-1:0] Dbg_Ra,
  output logic [DATA_W-1:0] Dbg_busD,
  input  logic              Ovf_Clr,
  output logic              Ovf_Flag,
  output logic [REG_AW-1:0] Ovf_Rw,
  output logic [CNT_W-1:0]  Wr_Count
);
  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] bus_w;
  logic              commit;
  logic              ovf_ev;

  assign bus_w  = wb.W_MemtoReg ? wb.W_Dout : wb.W_ALUout;
  assign commit = wb.W_RegWr & ~wb.W_Overflow & (wb.W_Rw != '0);
  assign ovf_ev = wb.W_RegWr & wb.W_Overflow;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      Wr_Count <= '0;
    end else if (commit) begin
      regs[wb.W_Rw] <= bus_w;
      Wr_Count      <= Wr_Count + 1'b1;
    end
  end

  // A new overflow beats a same-cycle clear; otherwise only the first overflow is recorded.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      Ovf_Flag <= 1'b0;
      Ovf_Rw   <= '0;
    end else if (ovf_ev && (!Ovf_Flag || Ovf_Clr)) begin
      Ovf_Flag <= 1'b1;
      Ovf_Rw   <= wb.W_Rw;
    end else if (Ovf_Clr && !ovf_ev) begin
      Ovf_Flag <= 1'b0;
      Ovf_Rw   <= '0;
    end
  end

  always_comb begin
    busA = '0;
    if (Ra != '0) begin
      busA = (commit && (Ra == wb.W_Rw)) ? bus_w : regs[Ra];
    end
  end

  always_comb begin
    busB = '0;
    if (Rb != '0) begin
      busB = (commit && (Rb == wb.W_Rw)) ? bus_w : regs[Rb];
    end
  end

  // Debug view shows architectural state only, never the in-flight writeback.
  always_comb begin
    Dbg_busD = '0;
    if (Dbg_Ra != '0) begin
      Dbg_busD = regs[Dbg_Ra];
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus pushes hand-computed expectations,
// a negedge monitor pops them and compares against the selected DUT output.
module tb_wb_regfile;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  localparam int SEL_BUSA = 0;
  localparam int SEL_BUSB = 1;
  localparam int SEL_DBG  = 2;
  localparam int SEL_FLAG = 3;
  localparam int SEL_ORW  = 4;
  localparam int SEL_CNT  = 5;

  logic              clk;
  logic              rst_n;
  logic [REG_AW-1:0] ra, rb, dbg_ra;
  logic              ovf_clr;
  logic [DATA_W-1:0] bus_a, bus_b, dbg_bus_d;
  logic              ovf_flag;
  logic [REG_AW-1:0] ovf_rw;
  logic [CNT_W-1:0]  wr_count;

  logic [DATA_W-1:0] exp_q[$];
  int                sel_q[$];
  string             name_q[$];
  int                n_vec = 0;
  int                n_err = 0;

  wb_regfile_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) wb ();

  wb_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .CLK      (clk),
    .RST_n    (rst_n),
    .wb       (wb.slave),
    .Ra       (ra),
    .Rb       (rb),
    .busA     (bus_a),
    .busB     (bus_b),
    .Dbg_Ra   (dbg_ra),
    .Dbg_busD (dbg_bus_d),
    .Ovf_Clr  (ovf_clr),
    .Ovf_Flag (ovf_flag),
    .Ovf_Rw   (ovf_rw),
    .Wr_Count (wr_count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic drive(input logic rst_v, input logic regwr, input logic ovf,
                       input logic m2r, input logic [REG_AW-1:0] rw,
                       input logic [DATA_W-1:0] dout, input logic [DATA_W-1:0] alu,
                       input logic clr);
    @(posedge clk);
    #1;
    rst_n            = rst_v;
    wb.W_RegWr       = regwr;
    wb.W_Overflow    = ovf;
    wb.W_MemtoReg    = m2r;
    wb.W_Rw          = rw;
    wb.W_Dout        = dout;
    wb.W_ALUout      = alu;
    ovf_clr          = clr;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic expect_val(input int sel, input logic [DATA_W-1:0] v, input string nm);
    sel_q.push_back(sel);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  // scoreboard monitor: compares every queued expectation at the falling edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      int                sel;
      logic [DATA_W-1:0] e;
      logic [DATA_W-1:0] act;
      string             nm;
      sel = sel_q.pop_front();
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      case (sel)
        SEL_BUSA: act = bus_a;
        SEL_BUSB: act = bus_b;
        SEL_DBG:  act = dbg_bus_d;
        SEL_FLAG: act = {{(DATA_W-1){1'b0}}, ovf_flag};
        SEL_ORW:  act = {{(DATA_W-REG_AW){1'b0}}, ovf_rw};
        default:  act = {{(DATA_W-CNT_W){1'b0}}, wr_count};
      endcase
      n_vec++;
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, e);
      end
    end
  end

  initial begin
    rst_n = 1'b0; ra = '0; rb = '0; dbg_ra = '0; ovf_clr = 1'b0;
    wb.W_RegWr = 1'b0; wb.W_Overflow = 1'b0; wb.W_MemtoReg = 1'b0;
    wb.W_Rw = '0; wb.W_Dout = '0; wb.W_ALUout = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);

    // write R5, then reset over it
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0, 32'h1234, 1'b0);
    ra = 5'd5; dbg_ra = 5'd5;
    expect_val(SEL_BUSA, 32'h1234, "bypass_r5");
    expect_val(SEL_DBG,  32'h0,    "dbg_no_bypass_r5");
    drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h77, 32'h77, 1'b0);
    expect_val(SEL_DBG, 32'h1234, "r5_before_reset");
    expect_val(SEL_CNT, 32'd1,    "cnt_before_reset");
    idle();
    expect_val(SEL_DBG,  32'h0, "reset_dbg_r5");
    expect_val(SEL_BUSA, 32'h0, "reset_busa_r5");
    expect_val(SEL_FLAG, 32'h0, "reset_flag");
    expect_val(SEL_ORW,  32'h0, "reset_ovf_rw");
    expect_val(SEL_CNT,  32'h0, "reset_cnt");

    // select memory data into R3
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 32'h11, 1'b0);
    ra = 5'd3; rb = 5'd3; dbg_ra = 5'd3;
    expect_val(SEL_BUSA, 32'hDEADBEEF, "sel_mem_busa");
    expect_val(SEL_BUSB, 32'hDEADBEEF, "sel_mem_busb");
    expect_val(SEL_DBG,  32'h0,        "r3_dbg_pre_edge");
    // write to R0 is dropped and not counted
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'hFFFFFFFF, 1'b0);
    ra = 5'd0; rb = 5'd3;
    expect_val(SEL_BUSA, 32'h0,        "r0_write_busa");
    expect_val(SEL_BUSB, 32'hDEADBEEF, "r3_busb_stored");
    expect_val(SEL_DBG,  32'hDEADBEEF, "r3_dbg_post_edge");
    expect_val(SEL_CNT,  32'd1,        "cnt_after_r3");
    // R7 = 5 via ALU path
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'hAAAA, 32'h5, 1'b0);
    ra = 5'd7;
    expect_val(SEL_BUSA, 32'h5, "sel_alu_busa");
    expect_val(SEL_CNT,  32'd1, "cnt_r0_not_counted");
    // overflow to R7 suppressed, not bypassed
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h0, 32'h80000000, 1'b0);
    ra = 5'd7;
    expect_val(SEL_BUSA, 32'h5, "ovf_no_bypass");
    expect_val(SEL_CNT,  32'd2, "cnt_after_r7");
    expect_val(SEL_FLAG, 32'h0, "flag_pre_edge");
    // second overflow to R9 keeps the first capture
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 32'h1, 1'b0);
    rb = 5'd9; dbg_ra = 5'd7;
    expect_val(SEL_BUSB, 32'h0, "ovf2_no_bypass");
    expect_val(SEL_DBG,  32'h5, "r7_unchanged");
    expect_val(SEL_FLAG, 32'h1, "flag_set");
    expect_val(SEL_ORW,  32'd7, "ovf_rw_first");
    idle();
    dbg_ra = 5'd9;
    expect_val(SEL_ORW,  32'd7, "ovf_rw_held");
    expect_val(SEL_DBG,  32'h0, "r9_unwritten");
    expect_val(SEL_CNT,  32'd2, "cnt_ovf_unchanged");
    // clear together with a new overflow: set wins
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 32'h0, 32'h3, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
    expect_val(SEL_FLAG, 32'h1,  "clr_vs_set_flag");
    expect_val(SEL_ORW,  32'd12, "clr_vs_set_rw");
    idle();
    expect_val(SEL_FLAG, 32'h0, "clr_flag");
    expect_val(SEL_ORW,  32'h0, "clr_rw");
    // overflow without RegWr is ignored
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 32'h0, 32'h9, 1'b0);
    // overflow with Rw=0 still records
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h9, 1'b0);
    expect_val(SEL_FLAG, 32'h0, "ovf_no_regwr_ignored");
    idle();
    expect_val(SEL_FLAG, 32'h1, "ovf_rw0_flag");
    expect_val(SEL_ORW,  32'h0, "ovf_rw0_rw");

    // counter wrap: 17 commits after reset with a 4-bit counter
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      logic [REG_AW-1:0] r;
      r = REG_AW'(i);
      drive(1'b1, 1'b1, 1'b0, 1'b0, r, 32'h0, 32'h100 + i, 1'b0);
      if (i == 17) expect_val(SEL_CNT, 32'd0, "cnt_wrap_to_0");
    end
    idle();
    expect_val(SEL_CNT, 32'd1, "cnt_wrap_17");
    for (int i = 1; i <= 17; i += 4) begin
      dbg_ra = REG_AW'(i);
      expect_val(SEL_DBG, 32'h100 + i, "wrap_reg_dbg");
      idle();
    end

    idle();
    idle();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
